// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV64 Funct3 encodings,
// controller state encoding, default geometry and the alignment helper.
package load_store_unit_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int IDX_W_DEF = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_DONE    = 3'd4
    } lsu_state_e;

    // Funct3[1:0] encodes the access size for every legal load and store.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] lo);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lo[0];
            2'b10:   mis = |lo[1:0];
            2'b11:   mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath shared by loads and stores: extracts and extends a
// load value from a doubleword, and merges store bytes into a doubleword.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [63:0] wdata,
    input  logic [2:0]  lane,
    input  logic [2:0]  funct3,
    output logic [63:0] load_data,
    output logic [63:0] merge_data
);

    logic [5:0]  shamt_s;
    logic [63:0] shifted_s;
    logic [63:0] mask_s;
    logic [63:0] lane_mask_s;

    assign shamt_s   = {lane, 3'b000};
    assign shifted_s = rdata >> shamt_s;

    // Load path: take the addressed lane from bit 0 and extend it per Funct3.
    always_comb begin
        load_data = 64'd0;
        case (funct3)
            F3_B:    load_data = {{56{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    load_data = {{48{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    load_data = {{32{shifted_s[31]}}, shifted_s[31:0]};
            F3_D:    load_data = shifted_s;
            F3_BU:   load_data = {56'd0, shifted_s[7:0]};
            F3_HU:   load_data = {48'd0, shifted_s[15:0]};
            F3_WU:   load_data = {32'd0, shifted_s[31:0]};
            default: load_data = 64'd0;
        endcase
    end

    // Store path: replace only the bytes covered by the access size at the lane.
    always_comb begin
        mask_s = 64'd0;
        case (funct3[1:0])
            2'b00:   mask_s = 64'h0000_0000_0000_00FF;
            2'b01:   mask_s = 64'h0000_0000_0000_FFFF;
            2'b10:   mask_s = 64'h0000_0000_FFFF_FFFF;
            2'b11:   mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
            default: mask_s = 64'd0;
        endcase
        lane_mask_s = mask_s << shamt_s;
        merge_data  = (rdata & ~lane_mask_s) | ((wdata << shamt_s) & lane_mask_s);
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit: turns byte-addressed requests into doubleword memory
// accesses, uses read-modify-write for sub-word stores and stalls the core
// until each access completes.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      ALUResult,
    input  logic [63:0]      ReadData2,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [2:0]       Funct3,
    output logic [IDX_W-1:0] MemAddr,
    output logic             MemRe,
    output logic             MemWe,
    output logic [63:0]      MemWdata,
    input  logic [63:0]      MemRdata,
    output logic [63:0]      LoadData,
    output logic             Stall,
    output logic             Done,
    output logic             Fault
);

    lsu_state_e       state_r;
    logic [2:0]       addr_lo_r;
    logic [63:0]      wdata_r;
    logic [2:0]       f3_r;
    logic             is_load_r;
    logic             mem_re_r;
    logic             mem_we_r;
    logic             done_r;
    logic             fault_r;
    logic [IDX_W-1:0] mem_addr_r;
    logic [63:0]      mem_wdata_r;
    logic [63:0]      load_data_r;

    logic             req_s;
    logic             misaligned_s;
    logic             range_s;
    logic             illegal_s;
    logic             fault_s;
    logic             stall_s;
    logic [63:0]      load_ext_s;
    logic [63:0]      merged_s;

    lsu_lane_align u_align (
        .rdata      (MemRdata),
        .wdata      (wdata_r),
        .lane       (addr_lo_r),
        .funct3     (f3_r),
        .load_data  (load_ext_s),
        .merge_data (merged_s)
    );

    // Classify the request presented in IDLE; any fault skips memory entirely.
    always_comb begin
        req_s        = MemRead | MemWrite;
        misaligned_s = lsu_misaligned(Funct3[1:0], ALUResult[2:0]);
        range_s      = (ALUResult[63:3] >= 61'(DEPTH));
        if (MemRead && MemWrite) begin
            illegal_s = 1'b1;
        end else if (MemRead) begin
            illegal_s = (Funct3 == 3'b111);
        end else if (MemWrite) begin
            illegal_s = Funct3[2];
        end else begin
            illegal_s = 1'b0;
        end
        fault_s = misaligned_s | range_s | illegal_s;
    end

    // Stall covers the accept cycle and every busy state; released in DONE and under reset.
    always_comb begin
        stall_s = 1'b0;
        if (!reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:    stall_s = req_s;
                ST_RD_REQ:  stall_s = 1'b1;
                ST_RD_WAIT: stall_s = 1'b1;
                ST_WR:      stall_s = 1'b1;
                ST_DONE:    stall_s = 1'b0;
                default:    stall_s = 1'b0;
            endcase
        end
    end

    // Access sequencer; strobes and results are registered on entry to each state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            addr_lo_r   <= 3'd0;
            wdata_r     <= 64'd0;
            f3_r        <= 3'd0;
            is_load_r   <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 64'd0;
            load_data_r <= 64'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r   <= 1'b0;
                    fault_r  <= 1'b0;
                    mem_re_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    if (req_s) begin
                        addr_lo_r <= ALUResult[2:0];
                        wdata_r   <= ReadData2;
                        f3_r      <= Funct3;
                        is_load_r <= MemRead;
                        if (fault_s) begin
                            load_data_r <= 64'd0;
                            done_r      <= 1'b1;
                            fault_r     <= 1'b1;
                            state_r     <= ST_DONE;
                        end else if (MemWrite && (Funct3 == F3_D)) begin
                            mem_addr_r  <= ALUResult[IDX_W+2:3];
                            mem_wdata_r <= ReadData2;
                            mem_we_r    <= 1'b1;
                            state_r     <= ST_WR;
                        end else begin
                            mem_addr_r <= ALUResult[IDX_W+2:3];
                            mem_re_r   <= 1'b1;
                            state_r    <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    mem_re_r <= 1'b0;
                    state_r  <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (is_load_r) begin
                        load_data_r <= load_ext_s;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        mem_wdata_r <= merged_s;
                        mem_we_r    <= 1'b1;
                        state_r     <= ST_WR;
                    end
                end
                ST_WR: begin
                    mem_we_r <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    fault_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_re_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    done_r   <= 1'b0;
                    fault_r  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign MemAddr  = mem_addr_r;
    assign MemRe    = mem_re_r;
    assign MemWe    = mem_we_r;
    assign MemWdata = mem_wdata_r;
    assign LoadData = load_data_r;
    assign Stall    = stall_s;
    assign Done     = done_r;
    assign Fault    = fault_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a registered-read data memory.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic [63:0] ALUResult;
    logic [63:0] ReadData2;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [4:0]  MemAddr;
    logic        MemRe;
    logic        MemWe;
    logic [63:0] MemWdata;
    logic [63:0] MemRdata;
    logic [63:0] LoadData;
    logic        Stall;
    logic        Done;
    logic        Fault;

    logic [63:0] mem [0:31];
    logic        mem_init;

    int          checks;
    int          errors;

    // results captured by the access task
    int          lat_v;
    int          re_cycle_v;
    int          we_cycle_v;
    logic [4:0]  re_addr_v;
    logic [4:0]  we_addr_v;
    logic [63:0] wdata_v;
    logic        both_v;
    logic        stall_bad_v;
    logic        fault_v;
    logic        saw_we;
    int          n_done;
    logic        switched;
    logic [63:0] first_ld;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ALUResult (ALUResult),
        .ReadData2 (ReadData2),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .MemAddr   (MemAddr),
        .MemRe     (MemRe),
        .MemWe     (MemWe),
        .MemWdata  (MemWdata),
        .MemRdata  (MemRdata),
        .LoadData  (LoadData),
        .Stall     (Stall),
        .Done      (Done),
        .Fault     (Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered read, write at the clock edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'hA5A5_5A5A_0000_0000 + 64'(i);
            MemRdata <= 64'd0;
        end else begin
            if (MemWe) mem[MemAddr] <= MemWdata;
            if (MemRe) MemRdata <= mem[MemAddr];
        end
    end

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        ALUResult = 64'd0;
        ReadData2 = 64'd0;
    endtask

    // One access from IDLE: present the request, follow it to Done, then release it.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] data,
                          input int exp_lat, input logic exp_fault, input string tag);
        MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; ReadData2 = data;
        #1;
        chk1({tag, " stall_accept"}, Stall, 1'b1);
        lat_v = 0; re_cycle_v = 0; we_cycle_v = 0; re_addr_v = 5'd0; we_addr_v = 5'd0;
        wdata_v = 64'd0; both_v = 1'b0; stall_bad_v = 1'b0; fault_v = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (MemRe) begin re_cycle_v = c; re_addr_v = MemAddr; end
            if (MemWe) begin we_cycle_v = c; we_addr_v = MemAddr; wdata_v = MemWdata; end
            if (MemRe && MemWe) both_v = 1'b1;
            if (Done) begin lat_v = c; fault_v = Fault; break; end
            if (!Stall) stall_bad_v = 1'b1;
        end
        chki({tag, " latency"}, lat_v, exp_lat);
        chk1({tag, " fault"}, fault_v, exp_fault);
        chk1({tag, " stall_done"}, Stall, 1'b0);
        chk1({tag, " re_we_overlap"}, both_v, 1'b0);
        chk1({tag, " stall_busy"}, stall_bad_v, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk1({tag, " no_reaccept_done"}, Done, 1'b0);
        chk1({tag, " no_reaccept_stall"}, Stall, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        mem_init = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk64("rst LoadData", LoadData, 64'd0);
        chk64("rst MemWdata", MemWdata, 64'd0);
        chk64("rst MemAddr", 64'(MemAddr), 64'd0);
        chk1("rst MemRe", MemRe, 1'b0);
        chk1("rst MemWe", MemWe, 1'b0);
        chk1("rst Done", Done, 1'b0);
        chk1("rst Fault", Fault, 1'b0);
        chk1("rst Stall", Stall, 1'b0);
        reset = 1'b1;
        mem_init = 1'b0;
        @(posedge clk); #1;

        // sd 0x8877665544332211 at 0x10
        access(1'b0, 1'b1, 3'b011, 64'h10, 64'h8877_6655_4433_2211, 2, 1'b0, "sd10");
        chki("sd10 we_cycle", we_cycle_v, 1);
        chki("sd10 re_cycle", re_cycle_v, 0);
        chk64("sd10 we_addr", 64'(we_addr_v), 64'd2);
        chk64("sd10 wdata", wdata_v, 64'h8877_6655_4433_2211);

        // loads from word 2
        access(1'b1, 1'b0, 3'b000, 64'h17, 64'd0, 3, 1'b0, "lb17");
        chk64("lb17 data", LoadData, 64'hFFFF_FFFF_FFFF_FF88);
        chk64("lb17 re_addr", 64'(re_addr_v), 64'd2);
        access(1'b1, 1'b0, 3'b100, 64'h17, 64'd0, 3, 1'b0, "lbu17");
        chk64("lbu17 data", LoadData, 64'h0000_0000_0000_0088);
        access(1'b1, 1'b0, 3'b010, 64'h14, 64'd0, 3, 1'b0, "lw14");
        chk64("lw14 data", LoadData, 64'hFFFF_FFFF_8877_6655);
        chki("lw14 we_cycle", we_cycle_v, 0);

        // sh 0xBEEF at 0x12; upper store-data bits must not leak into memory
        access(1'b0, 1'b1, 3'b001, 64'h12, 64'h1234_5678_9ABC_BEEF, 4, 1'b0, "sh12");
        chki("sh12 re_cycle", re_cycle_v, 1);
        chki("sh12 we_cycle", we_cycle_v, 3);
        chk64("sh12 re_addr", 64'(re_addr_v), 64'd2);
        chk64("sh12 we_addr", 64'(we_addr_v), 64'd2);
        chk64("sh12 wdata", wdata_v, 64'h8877_6655_BEEF_2211);
        access(1'b1, 1'b0, 3'b011, 64'h10, 64'd0, 3, 1'b0, "ld10");
        chk64("ld10 data", LoadData, 64'h8877_6655_BEEF_2211);

        // faults
        access(1'b1, 1'b0, 3'b010, 64'h0E, 64'd0, 1, 1'b1, "lw0E");
        chki("lw0E re_cycle", re_cycle_v, 0);
        chki("lw0E we_cycle", we_cycle_v, 0);
        chk64("lw0E data", LoadData, 64'd0);
        access(1'b0, 1'b1, 3'b011, 64'h104, 64'hDEAD_BEEF_DEAD_BEEF, 1, 1'b1, "sd104");
        chki("sd104 we_cycle", we_cycle_v, 0);
        access(1'b0, 1'b1, 3'b100, 64'h20, 64'h55, 1, 1'b1, "st_illegal");
        chki("st_illegal we_cycle", we_cycle_v, 0);
        access(1'b1, 1'b1, 3'b011, 64'h10, 64'h77, 1, 1'b1, "rd_wr_both");
        chki("rd_wr_both re_cycle", re_cycle_v, 0);

        // last in-range doubleword
        access(1'b1, 1'b0, 3'b011, 64'hF8, 64'd0, 3, 1'b0, "ldF8");
        chk64("ldF8 data", LoadData, 64'hA5A5_5A5A_0000_001F);
        chk64("ldF8 re_addr", 64'(re_addr_v), 64'd31);

        // reset in RD_WAIT of sb at 0x08
        MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b000; ALUResult = 64'h08; ReadData2 = 64'hFF;
        @(posedge clk); #1;
        chk1("abort re_req", MemRe, 1'b1);
        @(posedge clk); #1;
        chk1("abort wait_stall", Stall, 1'b1);
        reset = 1'b0;
        #1;
        chk64("abort LoadData", LoadData, 64'd0);
        chk64("abort MemWdata", MemWdata, 64'd0);
        chk64("abort MemAddr", 64'(MemAddr), 64'd0);
        chk1("abort MemRe", MemRe, 1'b0);
        chk1("abort Done", Done, 1'b0);
        chk1("abort Fault", Fault, 1'b0);
        chk1("abort Stall", Stall, 1'b0);
        saw_we = MemWe;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (MemWe) saw_we = 1'b1;
        end
        idle_inputs();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (MemWe) saw_we = 1'b1;
        end
        chk1("abort no_we", saw_we, 1'b0);
        access(1'b1, 1'b0, 3'b011, 64'h08, 64'd0, 3, 1'b0, "ld08");
        chk64("ld08 data", LoadData, 64'hA5A5_5A5A_0000_0001);

        // back-to-back: ld held through DONE, then lhu at 0x16
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b011; ALUResult = 64'h10; ReadData2 = 64'd0;
        n_done = 0; stall_bad_v = 1'b0; switched = 1'b0; first_ld = 64'd0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (Stall == Done) stall_bad_v = 1'b1;
            if (Done) begin
                n_done++;
                if (n_done == 1) first_ld = LoadData;
            end
            @(posedge clk); #1;
            if (n_done == 1 && !switched) begin
                Funct3 = 3'b101; ALUResult = 64'h16; switched = 1'b1;
                #1;
            end
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            if (Done) n_done++;
            @(posedge clk); #1;
        end
        chki("b2b done_count", n_done, 2);
        chk1("b2b stall_pattern", stall_bad_v, 1'b0);
        chk64("b2b ld data", first_ld, 64'h8877_6655_BEEF_2211);
        chk64("b2b lhu data", LoadData, 64'h0000_0000_0000_8877);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the ALU/register-file datapath and the doubleword data memory. Converts RV64 byte-addressed load/store requests (lb/lh/lw/ld/lbu/lhu/lwu, sb/sh/sw/sd) into doubleword-indexed memory accesses.
- Sub-word stores use read-modify-write sequencing. Load results are aligned and sign/zero-extended for writeback.
- Holds the core with Stall until each access completes.

Parameters:
- DEPTH, 32, number of 64-bit doublewords in data memory.
- IDX_W, 5, doubleword index width, equal to clog2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ALUResult  in  64  byte address of the access.
- ReadData2  in  64  store data; low bytes are used for sub-word stores.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- Funct3  in  3  access size/sign, RV64 encoding.
- MemAddr  out  IDX_W  doubleword index to memory.
- MemRe  out  1  memory read strobe; memory returns MemRdata one cycle later.
- MemWe  out  1  memory write strobe; memory writes at the clock edge.
- MemWdata  out  64  doubleword written to memory.
- MemRdata  in  64  registered memory read data.
- LoadData  out  64  aligned, extended load result.
- Stall  out  1  hold PC/writeback while high.
- Done  out  1  one-cycle pulse when the access completes.
- Fault  out  1  valid with Done: misaligned, out-of-range or illegal access.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: LoadData, MemWdata, MemAddr, MemRe, MemWe, Done, Fault. Stall is 0.
  - Internal address, data and Funct3 latches are cleared.
  - Reset during any state aborts the access. No MemWe is issued after reset asserts.
- States: IDLE, RD_REQ, RD_WAIT, WR, DONE.
- IDLE:
  - Stall = MemRead | MemWrite (combinational), so the core stalls in the accept cycle.
  - On a request, ALUResult, ReadData2 and Funct3 are latched at the clock edge.
  - Legal load -> RD_REQ. sd -> WR. sb/sh/sw -> RD_REQ (RMW). Any fault -> DONE with Fault latched.
- Fault conditions:
  - Misaligned: half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0.
  - Out of range: addr[63:3] ≥ DEPTH.
  - Illegal Funct3: load 111; store ≥100.
  - MemRead and MemWrite both high.
  - A faulting access never asserts MemRe or MemWe, and LoadData=0.
- RD_REQ: MemRe=1, MemAddr=addr[IDX_W+2:3], Stall=1 -> RD_WAIT.
- RD_WAIT: Stall=1. MemRdata is captured here.
  - Load: select byte lane addr[2:0], extend per Funct3, register into LoadData -> DONE.
  - Store: merge store bytes into the captured doubleword at lane addr[2:0] -> WR.
- WR: MemWe=1, MemAddr as above, Stall=1.
  - MemWdata = merged doubleword (RMW) or ReadData2 (sd) -> DONE.
- DONE: Done=1, Stall=0, so the core advances at this edge. Fault is valid. -> IDLE.
  - The request still present this cycle is not re-accepted.
- LoadData holds its value until the next completed load, or until a fault clears it.
- Latency from accept edge to Done: load 3 cycles, sd 2 cycles, sb/sh/sw 4 cycles, fault 1 cycle.
- Extension:
  - lb/lh/lw sign-extend from bit 7/15/31.
  - lbu/lhu/lwu zero-extend.
  - ld passes through.
- MemRe and MemWe are never high in the same cycle.
- Upper ALUResult bits are checked only through the range check; there is no wrap-around.

Decomposition:
- Shared package holds:
  - the Funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU;
  - the state enum;
  - DEPTH/IDX_W defaults.
- One natural sub-module, lsu_lane_align (combinational). It provides byte-lane extract plus extend for loads, and byte-lane merge for stores. It is shared by both paths and unit-tested separately.

Test Plan:
- Reset, then sd 0x8877665544332211 at 0x10 -> MemWe one cycle after accept, MemAddr=2, MemWdata=0x8877665544332211, Done at accept+2, Fault=0.
- Load word 2 (initialised as above) with three loads:
  - lb at 0x17 -> LoadData=0xFFFFFFFFFFFFFF88;
  - lbu at 0x17 -> 0x0000000000000088;
  - lw at 0x14 -> 0xFFFFFFFF88776655.
  - Each reaches Done at accept+3.
- sh 0xBEEF at 0x12 on that word:
  - MemRe then MemWe on MemAddr=2;
  - MemWdata=0x88776655BEEF2211;
  - the following ld at 0x10 returns 0x88776655BEEF2211.
- Misaligned accesses:
  - lw at 0x0E -> Fault=1, Done at accept+1, MemRe/MemWe never asserted, LoadData=0;
  - sd at 0x104 (index 32 ≥ DEPTH) -> Fault=1.
- Reset asserted during RD_WAIT of an sb at 0x08:
  - no MemWe is issued;
  - outputs go to 0 immediately;
  - after release, ld 0x08 returns the unmodified word.
- Back-to-back: MemRead held high through DONE, then a new lhu at 0x16 -> exactly one Done per instruction, with Stall low only in each DONE cycle.
